alu_op_sequencer: RTL and testbench

Registered, parametrised successor to the combinational ALU control decoder. It accepts one decoded instruction class (ALUOp, opType, shift amount) per handshake and issues one or more ALU micro-op selects, one per cycle. Multi-bit shifts become repeated single-bit SRL/SLL steps, and SWAP becomes two ADD steps. It sits between the instruction decoder and the ALU select input; the datapath uses StepIdx and StepLast to steer register writes.

---
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered ALU select sequencer.
// Expands decoded instruction classes into one ALU micro-op per cycle.
module alu_op_sequencer #(
    parameter int           SHAMT_W  = 3,
    parameter logic [2:0]   NOP_CODE = 3'b111
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [2:0]         ALUOp,
    input  logic [1:0]         opType,
    input  logic [SHAMT_W-1:0] ShAmt,
    input  logic               InValid,
    output logic               InReady,
    input  logic               Stall,
    output logic [2:0]         ALUOpFinal,
    output logic               OpValid,
    output logic [SHAMT_W-1:0] StepIdx,
    output logic               StepLast
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ISSUE = 1'b1;

    localparam logic [SHAMT_W-1:0] ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] TWO  = SHAMT_W'(2);
    localparam logic [SHAMT_W-1:0] ZERO = '0;

    logic               state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [SHAMT_W-1:0] n_q, n_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [2:0]         dec_sel;
    logic [SHAMT_W-1:0] dec_n;
    logic               accept;
    logic               advance;
    logic               last;

    // Decode the presented instruction into its select and step count
    always_comb begin
        dec_sel = NOP_CODE;
        dec_n   = ONE;
        unique case (ALUOp)
            3'b000: begin
                unique case (opType)
                    2'b00: dec_sel = 3'b000;
                    2'b01: dec_sel = 3'b100;
                    2'b10: dec_sel = 3'b101;
                    2'b11: dec_sel = 3'b110;
                endcase
            end
            3'b001: dec_sel = 3'b001;
            3'b010, 3'b011: begin
                if (ShAmt == ZERO) begin
                    dec_sel = NOP_CODE;
                    dec_n   = ONE;
                end else begin
                    dec_sel = ALUOp;
                    dec_n   = ShAmt;
                end
            end
            3'b100, 3'b101: dec_sel = 3'b000;
            3'b110: dec_sel = NOP_CODE;
            3'b111: begin
                unique case (opType)
                    2'b00: dec_sel = 3'b000;
                    2'b01: dec_sel = 3'b001;
                    2'b10: begin
                        dec_sel = 3'b000;
                        dec_n   = TWO;
                    end
                    2'b11: dec_sel = NOP_CODE;
                endcase
            end
        endcase
    end

    assign OpValid    = (state_q == ST_ISSUE);
    assign last       = OpValid & (cnt_q == (n_q - ONE));
    assign StepLast   = last;
    assign InReady    = Reset_n & (~OpValid | (last & ~Stall));
    assign accept     = InValid & InReady;
    assign advance    = OpValid & ~Stall;
    assign ALUOpFinal = sel_q;
    assign StepIdx    = cnt_q;

    // Next-state: accept wins, then completion, then step advance
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_ISSUE;
            sel_d   = dec_sel;
            n_d     = dec_n;
            cnt_d   = ZERO;
        end else if (advance && last) begin
            state_d = ST_IDLE;
            sel_d   = NOP_CODE;
            n_d     = ONE;
            cnt_d   = ZERO;
        end else if (advance) begin
            cnt_d   = cnt_q + ONE;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= NOP_CODE;
            n_q     <= ONE;
            cnt_q   <= ZERO;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the ALU op sequencer.
// Inputs change 1ns after each rising edge; outputs are checked 2ns after.
module tb_alu_op_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] ALUOp;
    logic [1:0] opType;
    logic [2:0] ShAmt;
    logic       InValid;
    logic       InReady;
    logic       Stall;
    logic [2:0] ALUOpFinal;
    logic       OpValid;
    logic [2:0] StepIdx;
    logic       StepLast;

    int total = 0;
    int bad   = 0;

    // Expected select per {ALUOp,opType}, hand-derived from the decode list
    logic [2:0] exp_sel [0:31] = '{
        3'd0, 3'd4, 3'd5, 3'd6,
        3'd1, 3'd1, 3'd1, 3'd1,
        3'd2, 3'd2, 3'd2, 3'd2,
        3'd3, 3'd3, 3'd3, 3'd3,
        3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0,
        3'd7, 3'd7, 3'd7, 3'd7,
        3'd0, 3'd1, 3'd0, 3'd7
    };

    alu_op_sequencer #(.SHAMT_W(3), .NOP_CODE(3'b111)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ALUOp      (ALUOp),
        .opType     (opType),
        .ShAmt      (ShAmt),
        .InValid    (InValid),
        .InReady    (InReady),
        .Stall      (Stall),
        .ALUOpFinal (ALUOpFinal),
        .OpValid    (OpValid),
        .StepIdx    (StepIdx),
        .StepLast   (StepLast)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [1:0] ty,
                           input logic [2:0] sh);
        ALUOp   = op;
        opType  = ty;
        ShAmt   = sh;
        InValid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] sel,
                           input logic v, input logic [2:0] idx,
                           input logic lst);
        chk({tag, ".sel"}, 32'(ALUOpFinal), 32'(sel));
        chk({tag, ".vld"}, 32'(OpValid), 32'(v));
        chk({tag, ".idx"}, 32'(StepIdx), 32'(idx));
        chk({tag, ".last"}, 32'(StepLast), 32'(lst));
    endtask

    initial begin
        Reset_n = 1'b0;
        ALUOp   = '0;
        opType  = '0;
        ShAmt   = '0;
        InValid = 1'b0;
        Stall   = 1'b0;

        #12;
        chk_out("rst", 3'd7, 1'b0, 3'd0, 1'b0);
        chk("rst.rdy", 32'(InReady), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        #1 chk("idle.rdy", 32'(InReady), 32'd1);

        // Single XOR
        present(3'b000, 2'b01, 3'd0);
        cyc();
        InValid = 1'b0;
        #1;
        chk_out("xor", 3'd4, 1'b1, 3'd0, 1'b1);
        chk("xor.rdy", 32'(InReady), 32'd1);
        cyc();
        #1 chk_out("xor.idle", 3'd7, 1'b0, 3'd0, 1'b0);

        // SLL by 5
        present(3'b011, 2'b00, 3'd5);
        cyc();
        InValid = 1'b0;
        ShAmt   = 3'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_out($sformatf("sll5[%0d]", i), 3'd3, 1'b1, 3'(i), i == 4);
            chk($sformatf("sll5.rdy[%0d]", i), 32'(InReady),
                32'(i == 4));
            cyc();
        end
        #1 chk_out("sll5.idle", 3'd7, 1'b0, 3'd0, 1'b0);

        // SLL by 0 -> single NOP step
        present(3'b011, 2'b00, 3'd0);
        cyc();
        InValid = 1'b0;
        #1 chk_out("sll0", 3'd7, 1'b1, 3'd0, 1'b1);
        cyc();
        #1 chk("sll0.idle", 32'(OpValid), 32'd0);

        // SWAP then ADDI with no bubble
        present(3'b111, 2'b10, 3'd0);
        cyc();
        InValid = 1'b0;
        #1 chk_out("swap0", 3'd0, 1'b1, 3'd0, 1'b0);
        chk("swap0.rdy", 32'(InReady), 32'd0);
        cyc();
        present(3'b000, 2'b00, 3'd0);
        #1 chk_out("swap1", 3'd0, 1'b1, 3'd1, 1'b1);
        chk("swap1.rdy", 32'(InReady), 32'd1);
        cyc();
        InValid = 1'b0;
        #1 chk_out("addi", 3'd0, 1'b1, 3'd0, 1'b1);
        cyc();
        #1 chk("addi.idle", 32'(OpValid), 32'd0);

        // SRL by 3, stall 4 cycles on step 1, then stall on last step
        present(3'b010, 2'b00, 3'd3);
        cyc();
        InValid = 1'b0;
        ShAmt   = 3'd6;
        #1 chk_out("srl.s0", 3'd2, 1'b1, 3'd0, 1'b0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            Stall = 1'b1;
            #1;
            chk_out($sformatf("srl.hold[%0d]", i), 3'd2, 1'b1, 3'd1, 1'b0);
            chk($sformatf("srl.hold.rdy[%0d]", i), 32'(InReady), 32'd0);
            cyc();
        end
        Stall = 1'b0;
        #1 chk_out("srl.s1", 3'd2, 1'b1, 3'd1, 1'b0);
        cyc();
        Stall = 1'b1;
        present(3'b000, 2'b01, 3'd0);
        #1 chk_out("srl.s2", 3'd2, 1'b1, 3'd2, 1'b1);
        chk("srl.lstall.rdy", 32'(InReady), 32'd0);
        cyc();
        InValid = 1'b0;
        #1 chk_out("srl.defer", 3'd2, 1'b1, 3'd2, 1'b1);
        Stall = 1'b0;
        #1 chk("srl.rel.rdy", 32'(InReady), 32'd1);
        cyc();
        #1 chk_out("srl.idle", 3'd7, 1'b0, 3'd0, 1'b0);

        // Reset in the middle of SLL by 7
        present(3'b011, 2'b00, 3'd7);
        cyc();
        InValid = 1'b0;
        cyc();
        cyc();
        cyc();
        #1 chk_out("sll7.s3", 3'd3, 1'b1, 3'd3, 1'b0);
        Reset_n = 1'b0;
        #1 chk_out("midrst", 3'd7, 1'b0, 3'd0, 1'b0);
        chk("midrst.rdy", 32'(InReady), 32'd0);
        cyc();
        Reset_n = 1'b1;
        present(3'b000, 2'b10, 3'd0);
        #1 chk("post.rdy", 32'(InReady), 32'd1);
        cyc();
        InValid = 1'b0;
        #1 chk_out("xred", 3'd5, 1'b1, 3'd0, 1'b1);
        cyc();

        // Full decode sweep
        for (int k = 0; k < 32; k++) begin
            present(3'(k >> 2), 2'(k), 3'd1);
            cyc();
            InValid = 1'b0;
            #1;
            chk($sformatf("sweep.sel[%0d]", k), 32'(ALUOpFinal),
                32'(exp_sel[k]));
            chk($sformatf("sweep.last[%0d]", k), 32'(StepLast),
                32'(k != 30));
            if (k == 30) cyc();
            cyc();
        end
        #1 chk("sweep.idle", 32'(OpValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
